tilt_fall_detect: RTL and testbench

TILT_FALL_DETECT -- requirements
Module: tilt_fall_detect

---
 rtl/tilt_fall_pkg.sv | 19 +
 rtl/angle_abs_diff.sv | 24 ++
 rtl/tilt_fall_detect.sv | 161 ++++++++++++++++
 tb/tb_tilt_fall_detect.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tilt_fall_pkg.sv
// rtl/tilt_fall_pkg.sv - shared widths, state encoding and default thresholds for tilt_fall_detect
package tilt_fall_pkg;

  localparam int ANGLE_W = 16;
  localparam int CNT_W   = 16;

  localparam int unsigned DEF_TILT_THR     = 8192;
  localparam int unsigned DEF_RATE_THR     = 1024;
  localparam int unsigned DEF_WIN_SAMPLES  = 8;
  localparam int unsigned DEF_HOLD_SAMPLES = 16;

  typedef enum logic [1:0] {
    ST_UPRIGHT = 2'd0,
    ST_IMPACT  = 2'd1,
    ST_LYING   = 2'd2,
    ST_ALARM   = 2'd3
  } state_e;

endpackage

// File: rtl/angle_abs_diff.sv
// rtl/angle_abs_diff.sv - wrapped binary-angle difference with saturating absolute value
module angle_abs_diff
  import tilt_fall_pkg::*;
(
  input  logic signed [ANGLE_W-1:0] a_i,
  input  logic signed [ANGLE_W-1:0] b_i,
  output logic        [ANGLE_W-1:0] mag_o
);

  logic [ANGLE_W-1:0] diff;

  // Subtract modulo 2^16 so angles wrap at +/-180 deg; -180 has no positive twin, clamp it
  always_comb begin
    diff = a_i - b_i;
    if (diff == {1'b1, {(ANGLE_W-1){1'b0}}}) begin
      mag_o = {1'b0, {(ANGLE_W-1){1'b1}}};
    end else if (diff[ANGLE_W-1]) begin
      mag_o = -diff;
    end else begin
      mag_o = diff;
    end
  end

endmodule

// File: rtl/tilt_fall_detect.sv
// rtl/tilt_fall_detect.sv - impact-then-lying fall detector on a stream of binary angle samples
module tilt_fall_detect
  import tilt_fall_pkg::*;
#(
  parameter int unsigned TILT_THR     = DEF_TILT_THR,
  parameter int unsigned RATE_THR     = DEF_RATE_THR,
  parameter int unsigned WIN_SAMPLES  = DEF_WIN_SAMPLES,
  parameter int unsigned HOLD_SAMPLES = DEF_HOLD_SAMPLES
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      angle_valid,
  input  logic signed [ANGLE_W-1:0] angle,
  input  logic                      ref_load,
  input  logic                      clear,
  output logic        [ANGLE_W-1:0] tilt_mag,
  output logic                      out_valid,
  output logic                      fall_alarm,
  output logic        [1:0]         state_o,
  output logic        [7:0]         fall_count
);

  localparam logic [ANGLE_W-1:0] TILT_L = ANGLE_W'(TILT_THR);
  localparam logic [ANGLE_W-1:0] RATE_L = ANGLE_W'(RATE_THR);
  localparam logic [CNT_W-1:0]   WIN_L  = CNT_W'(WIN_SAMPLES);
  localparam logic [CNT_W-1:0]   HOLD_L = CNT_W'(HOLD_SAMPLES);

  logic signed [ANGLE_W-1:0] ref_q, ref_d;
  logic signed [ANGLE_W-1:0] prev_q, prev_d;
  logic                      prev_vld_q, prev_vld_d;
  logic [ANGLE_W-1:0]        tilt_mag_q, tilt_mag_d;
  logic                      out_valid_q, out_valid_d;
  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]          hold_cnt_q, hold_cnt_d;
  logic [7:0]                fall_count_q, fall_count_d;

  logic [ANGLE_W-1:0] tilt_raw;
  logic [ANGLE_W-1:0] delta_raw;
  logic [ANGLE_W-1:0] delta;
  logic [CNT_W-1:0]   win_inc;
  logic [CNT_W-1:0]   hold_inc;

  // Tilt is measured against the reference held before this edge, so a same-cycle ref_load
  // only affects later samples
  angle_abs_diff u_tilt (
    .a_i   (angle),
    .b_i   (ref_q),
    .mag_o (tilt_raw)
  );

  angle_abs_diff u_delta (
    .a_i   (angle),
    .b_i   (prev_q),
    .mag_o (delta_raw)
  );

  // Without a previous sample there is no rate of change to report
  assign delta    = prev_vld_q ? delta_raw : '0;
  assign win_inc  = win_cnt_q + CNT_W'(1);
  assign hold_inc = hold_cnt_q + CNT_W'(1);

  // Next-state: sample bookkeeping always follows angle_valid, clear overrides the FSM
  always_comb begin
    ref_d        = ref_q;
    prev_d       = prev_q;
    prev_vld_d   = prev_vld_q;
    tilt_mag_d   = tilt_mag_q;
    out_valid_d  = angle_valid;
    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    fall_count_d = fall_count_q;

    if (ref_load) begin
      ref_d = angle;
    end

    if (angle_valid) begin
      prev_d     = angle;
      prev_vld_d = 1'b1;
      tilt_mag_d = tilt_raw;
    end

    if (clear) begin
      state_d    = ST_UPRIGHT;
      win_cnt_d  = '0;
      hold_cnt_d = '0;
    end else if (angle_valid) begin
      case (state_q)
        ST_UPRIGHT: begin
          if (delta > RATE_L) begin
            state_d   = ST_IMPACT;
            win_cnt_d = '0;
          end
        end
        ST_IMPACT: begin
          if (tilt_raw >= TILT_L) begin
            state_d    = ST_LYING;
            hold_cnt_d = CNT_W'(1);
          end else if (win_inc >= WIN_L) begin
            state_d   = ST_UPRIGHT;
            win_cnt_d = '0;
          end else begin
            win_cnt_d = win_inc;
          end
        end
        ST_LYING: begin
          if (tilt_raw < TILT_L) begin
            state_d    = ST_UPRIGHT;
            hold_cnt_d = '0;
          end else if (hold_inc >= HOLD_L) begin
            state_d      = ST_ALARM;
            hold_cnt_d   = '0;
            fall_count_d = (fall_count_q == 8'hFF) ? fall_count_q : fall_count_q + 8'd1;
          end else begin
            hold_cnt_d = hold_inc;
          end
        end
        ST_ALARM: begin
          state_d = ST_ALARM;
        end
        default: begin
          state_d = ST_UPRIGHT;
        end
      endcase
    end
  end

  // State and output registers; reset wipes all history including the fall count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_q        <= '0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      tilt_mag_q   <= '0;
      out_valid_q  <= 1'b0;
      state_q      <= ST_UPRIGHT;
      win_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      fall_count_q <= '0;
    end else begin
      ref_q        <= ref_d;
      prev_q       <= prev_d;
      prev_vld_q   <= prev_vld_d;
      tilt_mag_q   <= tilt_mag_d;
      out_valid_q  <= out_valid_d;
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      fall_count_q <= fall_count_d;
    end
  end

  assign tilt_mag   = tilt_mag_q;
  assign out_valid  = out_valid_q;
  assign fall_alarm = (state_q == ST_ALARM);
  assign state_o    = state_q;
  assign fall_count = fall_count_q;

endmodule

// File: tb/tb_tilt_fall_detect.sv
// tb/tb_tilt_fall_detect.sv - self-checking bench for tilt_fall_detect with a behavioural fall model
module tb_tilt_fall_detect;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               angle_valid = 1'b0;
  logic signed [15:0] angle = '0;
  logic               ref_load = 1'b0;
  logic               clear = 1'b0;
  logic        [15:0] tilt_mag;
  logic               out_valid;
  logic               fall_alarm;
  logic        [1:0]  state_o;
  logic        [7:0]  fall_count;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model: 0 upright, 1 impact, 2 lying, 3 alarm
  int m_state, m_ref, m_prev, m_win, m_hold, m_count, m_tilt;
  bit m_prev_vld, m_ov;

  tilt_fall_detect dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .angle_valid (angle_valid),
    .angle       (angle),
    .ref_load    (ref_load),
    .clear       (clear),
    .tilt_mag    (tilt_mag),
    .out_valid   (out_valid),
    .fall_alarm  (fall_alarm),
    .state_o     (state_o),
    .fall_count  (fall_count)
  );

  always #5 clk = ~clk;

  // shortest angular distance in 1/65536 turns, clamped to 32767
  function automatic int absd(input int a, input int b);
    int d;
    d = (a - b) & 32'hFFFF;
    if (d >= 32768) d = d - 65536;
    if (d < 0) d = -d;
    if (d > 32767) d = 32767;
    return d;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ref = 0; m_prev = 0; m_win = 0; m_hold = 0;
    m_count = 0; m_tilt = 0; m_prev_vld = 0; m_ov = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // one clock of stimulus; model advances alongside, outputs readable #1 after the edge
  task automatic step(input bit v, input int a, input bit rl, input bit clr);
    int tilt, delta;
    @(negedge clk);
    angle_valid = v;
    angle       = 16'(a);
    ref_load    = rl;
    clear       = clr;
    tilt  = absd(a, m_ref);
    delta = m_prev_vld ? absd(a, m_prev) : 0;
    if (clr) begin
      m_state = 0; m_win = 0; m_hold = 0;
    end else if (v) begin
      case (m_state)
        0: if (delta > 1024) begin m_state = 1; m_win = 0; end
        1: begin
          if (tilt >= 8192) begin m_state = 2; m_hold = 1; end
          else begin
            m_win++;
            if (m_win == 8) begin m_state = 0; m_win = 0; end
          end
        end
        2: begin
          if (tilt < 8192) m_state = 0;
          else begin
            m_hold++;
            if (m_hold == 16) begin
              m_state = 3;
              if (m_count < 255) m_count++;
            end
          end
        end
        default: ;
      endcase
    end
    if (v) begin
      m_prev = a; m_prev_vld = 1; m_tilt = tilt;
    end
    if (rl) m_ref = a;
    m_ov = v;
    @(posedge clk);
    #1;
    angle_valid = 1'b0;
    ref_load    = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({tilt_mag, out_valid, fall_alarm, state_o, fall_count} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: tilt=%0d ov=%0b alarm=%0b state=%0d count=%0d expected all 0",
               tilt_mag, out_valid, fall_alarm, state_o, fall_count);
    end
    apply_reset();
  endtask

  task automatic test_steady();
    int pulses = 0;
    bit bad = 0;
    apply_reset();
    step(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0);
      if (out_valid === 1'b1) pulses++;
      if (state_o !== 2'd0 || fall_alarm !== 1'b0) bad = 1;
    end
    step(0, 0, 0, 0);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL steady_idle_ov: out_valid=%0b expected 0", out_valid);
    end
    n_tests++;
    if (pulses != 20) begin
      n_fail++; $display("FAIL steady_pulses: got %0d expected 20", pulses);
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL steady_state: left UPRIGHT or alarmed, expected stay 0");
    end
  endtask

  task automatic test_ramp();
    bit bad = 0;
    apply_reset();
    step(0, 0, 1, 0);
    for (int k = 0; k <= 32; k++) begin
      step(1, k * 512, 0, 0);
      if (state_o !== 2'd0 || fall_alarm !== 1'b0) bad = 1;
    end
    n_tests++;
    if (bad || tilt_mag !== 16'd16384) begin
      n_fail++; $display("FAIL ramp: bad=%0b tilt=%0d expected upright, tilt 16384", bad, tilt_mag);
    end
  endtask

  task automatic test_fall();
    apply_reset();
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 3000, 0, 0);
    n_tests++;
    if (state_o !== 2'd1) begin
      n_fail++; $display("FAIL fall_impact: state=%0d expected 1", state_o);
    end
    step(1, 9000, 0, 0);
    n_tests++;
    if (state_o !== 2'd2 || tilt_mag !== 16'd9000) begin
      n_fail++; $display("FAIL fall_lying: state=%0d tilt=%0d expected 2, 9000", state_o, tilt_mag);
    end
    for (int i = 0; i < 14; i++) step(1, 16384, 0, 0);
    n_tests++;
    if (state_o !== 2'd2 || fall_alarm !== 1'b0) begin
      n_fail++; $display("FAIL fall_pre_alarm: state=%0d alarm=%0b expected 2, 0", state_o, fall_alarm);
    end
    step(1, 16384, 0, 0);
    n_tests++;
    if (state_o !== 2'd3 || fall_alarm !== 1'b1 || fall_count !== 8'd1) begin
      n_fail++; $display("FAIL fall_alarm: state=%0d alarm=%0b count=%0d expected 3, 1, 1",
                         state_o, fall_alarm, fall_count);
    end
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    n_tests++;
    if (state_o !== 2'd3 || tilt_mag !== 16'd0) begin
      n_fail++; $display("FAIL alarm_persist: state=%0d tilt=%0d expected 3, 0", state_o, tilt_mag);
    end
    step(0, 0, 0, 1);
    n_tests++;
    if (state_o !== 2'd0 || fall_alarm !== 1'b0 || fall_count !== 8'd1) begin
      n_fail++; $display("FAIL alarm_clear: state=%0d alarm=%0b count=%0d expected 0, 0, 1",
                         state_o, fall_alarm, fall_count);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 3000, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 3000, 0, 0);
    n_tests++;
    if (state_o !== 2'd1) begin
      n_fail++; $display("FAIL timeout_7: state=%0d expected 1", state_o);
    end
    step(1, 3000, 0, 0);
    n_tests++;
    if (state_o !== 2'd0 || fall_alarm !== 1'b0) begin
      n_fail++; $display("FAIL timeout_8: state=%0d alarm=%0b expected 0, 0", state_o, fall_alarm);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    step(0, 32000, 1, 0);
    step(1, -32000, 0, 0);
    n_tests++;
    if (tilt_mag !== 16'd1536) begin
      n_fail++; $display("FAIL wrap_1536: tilt=%0d expected 1536", tilt_mag);
    end
    step(0, 0, 1, 0);
    step(1, -32768, 0, 0);
    n_tests++;
    if (tilt_mag !== 16'd32767) begin
      n_fail++; $display("FAIL wrap_sat: tilt=%0d expected 32767", tilt_mag);
    end
    step(1, 5000, 1, 0);
    n_tests++;
    if (tilt_mag !== 16'd5000) begin
      n_fail++; $display("FAIL ref_same_cycle: tilt=%0d expected 5000", tilt_mag);
    end
    step(1, 5000, 0, 0);
    n_tests++;
    if (tilt_mag !== 16'd0) begin
      n_fail++; $display("FAIL ref_after_load: tilt=%0d expected 0", tilt_mag);
    end
  endtask

  task automatic test_clear_priority();
    apply_reset();
    step(1, 0, 0, 0);
    step(1, 3000, 0, 0);
    step(1, 20000, 0, 1);
    n_tests++;
    if (state_o !== 2'd0 || tilt_mag !== 16'd20000 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL clear_priority: state=%0d tilt=%0d ov=%0b expected 0, 20000, 1",
                         state_o, tilt_mag, out_valid);
    end
    step(1, 20000, 0, 0);
    n_tests++;
    if (state_o !== 2'd0) begin
      n_fail++; $display("FAIL clear_prev_update: state=%0d expected 0", state_o);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1, 0, 0, 0);
    step(1, 3000, 0, 0);
    step(1, 9000, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({tilt_mag, out_valid, fall_alarm, state_o, fall_count} !== 28'd0) begin
      n_fail++; $display("FAIL async_reset: tilt=%0d ov=%0b alarm=%0b state=%0d count=%0d expected all 0",
                         tilt_mag, out_valid, fall_alarm, state_o, fall_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step(1, 5000, 0, 0);
    n_tests++;
    if (state_o !== 2'd0 || tilt_mag !== 16'd5000) begin
      n_fail++; $display("FAIL post_reset_delta: state=%0d tilt=%0d expected 0, 5000", state_o, tilt_mag);
    end
  endtask

  task automatic test_random();
    int cur = 0;
    int r;
    bit v, rl, clr;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) cur = int'($urandom_range(0, 65535)) - 32768;
      else if (r < 20) cur = cur + int'($urandom_range(0, 4000)) - 2000;
      else cur = cur + int'($urandom_range(0, 600)) - 300;
      cur = ((cur + 32768) & 32'hFFFF) - 32768;
      v   = ($urandom_range(0, 9) != 0);
      rl  = ($urandom_range(0, 99) < 3);
      clr = ($urandom_range(0, 99) < 2);
      step(v, cur, rl, clr);
      n_tests++;
      if (state_o !== 2'(m_state) || tilt_mag !== 16'(m_tilt) || out_valid !== m_ov ||
          fall_alarm !== (m_state == 3) || fall_count !== 8'(m_count)) begin
        n_fail++;
        $display("FAIL random[%0d]: state=%0d tilt=%0d ov=%0b alarm=%0b count=%0d expected %0d %0d %0b %0b %0d",
                 i, state_o, tilt_mag, out_valid, fall_alarm, fall_count,
                 m_state, m_tilt, m_ov, (m_state == 3), m_count);
      end
    end
  endtask

  task automatic test_saturation();
    bit bad = 0;
    apply_reset();
    for (int n = 0; n < 260; n++) begin
      step(1, 0, 0, 0);
      step(1, 3000, 0, 0);
      for (int i = 0; i < 16; i++) step(1, 16384, 0, 0);
      if (state_o !== 2'(m_state) || fall_count !== 8'(m_count)) bad = 1;
      step(0, 0, 0, 1);
    end
    n_tests++;
    if (bad || fall_count !== 8'd255) begin
      n_fail++; $display("FAIL count_saturate: count=%0d bad=%0b expected 255", fall_count, bad);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_steady();
    test_ramp();
    test_fall();
    test_timeout();
    test_wrap();
    test_clear_priority();
    test_async_reset();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
